cfg_reg_arbiter: RTL
====================

CFG_REG_ARBITER -- requirements
Module: cfg_reg_arbiter

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 4, giving the highest valid register address.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  write request from requester 0 / 1 (0 = SPI peripheral, 1 = on-chip sequencer).
REQ-005 SHALL have ports req0_addr / req1_addr  input  7  target register address.
REQ-006 SHALL have ports req0_data / req1_data  input  8  write data.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  one-cycle completion pulse.
REQ-008 SHALL have ports req0_err / req1_err  output  1  one-cycle pulse, coincident with ready, for an out-of-range address.
REQ-009 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  configuration registers at addresses 0..4.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-011 SHALL have port err_count  output  8  rejected-write count; present only with CFG_ERR_COUNT_EN.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, RESP; encoding free.
REQ-013 IDLE: if any valid, SHALL latch the winner's addr/data and grant id, then go to WRITE; otherwise SHALL stay in IDLE.
REQ-014 WRITE: if latched addr <= MAX_ADDR, SHALL update exactly that register; else SHALL write nothing; SHALL always go to RESP.
REQ-015 RESP: SHALL pulse ready of the granted requester for one cycle, plus err if the address was out of range; SHALL then go to IDLE.
REQ-016 Latency: valid sampled in IDLE at cycle N; register updated at edge ending N+1; ready high in cycle N+2; next grant no earlier than N+3.
REQ-017 Requesters SHALL hold valid/addr/data stable through the ready cycle; the arbiter SHALL use latched values, so a mid-transaction drop of valid SHALL NOT affect the write.
REQ-018 Arbitration SHALL be two-way round-robin: a lone request is granted; on simultaneous requests, the requester not granted last wins.
REQ-019 The last-grant pointer SHALL update only on grant and SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 Requests arriving while busy SHALL be held off (no ready) and SHALL NOT be lost.
REQ-021 Register width SHALL be 8 bits; data SHALL be written verbatim, with no masking or arithmetic.
REQ-022 ready/err SHALL never be asserted for the non-granted requester.

Reset
REQ-023 On rst: state = IDLE, all five registers = 0x00, ready/err = 0, busy = 0, last-grant = 1, err_count = 0.
REQ-024 Reset mid-transaction SHALL abandon the pending write, with no register update and no ready pulse.

Configuration
REQ-025 With CFG_ERR_COUNT_EN defined: err_count SHALL increment on each out-of-range write in WRITE and SHALL saturate at 0xFF.
REQ-026 Without CFG_ERR_COUNT_EN: err_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Shared package cfg_reg_pkg SHALL hold the register address constants (0..4), MAX_ADDR default, and FSM state typedef.
REQ-028 Grant selection SHALL live in sub-module rr_arb2 (two request inputs, last-grant pointer, one grant output).

Verification
REQ-029 Single write: req0 addr 4, data 0x80 at cycle N -> pwm_duty_cycle = 0x80 from N+2; req0_ready pulse in N+2; req0_err = 0.
REQ-030 Tie after reset: req0 (addr 0, 0x11) and req1 (addr 1, 0x22) together -> req0 served first, req1 three cycles later; both registers set.
REQ-031 Fairness: both requesters streaming continuously -> grants alternate 0,1,0,1 over 8 transactions.
REQ-032 Out of range: req1 addr 5, data 0xFF -> no register changes; req1_ready and req1_err pulse together; err_count = 1 if enabled.
REQ-033 Reset in WRITE: rst asserted during WRITE for req0 addr 2 -> en_reg_pwm_7_0 = 0x00, no ready pulse, busy = 0 next cycle.
REQ-034 Saturation (macro on): 300 out-of-range writes -> err_count = 0xFF.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// rtl/cfg_reg_pkg.sv - register map, arbiter defaults and FSM state type for cfg_reg_arbiter
package cfg_reg_pkg;

    localparam int ADDR_W           = 7;
    localparam int DATA_W           = 8;
    localparam int MAX_ADDR_DEFAULT = 4;

    localparam logic [ADDR_W-1:0] ADDR_EN_REG_OUT_7_0  = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_EN_REG_OUT_15_8 = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_EN_REG_PWM_7_0  = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_EN_REG_PWM_15_8 = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY_CYCLE  = 7'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant selection with last-grant pointer
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic grant
);

    logic last_grant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_en && (req0 || req1)) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// rtl/cfg_reg_arbiter.sv - two-requester arbiter for the configuration register file
// Optional rejected-write counter port err_count enabled by CFG_ERR_COUNT_EN.
module cfg_reg_arbiter
    import cfg_reg_pkg::*;
#(
    parameter int MAX_ADDR = MAX_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              req1_err,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              busy
`ifdef CFG_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam logic [ADDR_W-1:0] MAX_ADDR_C = ADDR_W'(MAX_ADDR);

    state_t            state;
    logic              grant;
    logic              arb_en;
    logic              gid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              addr_ok;

    assign arb_en  = (state == IDLE);
    assign addr_ok = (addr_q <= MAX_ADDR_C);

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0_valid),
        .req1     (req1_valid),
        .grant_en (arb_en),
        .grant    (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            gid_q           <= 1'b0;
            addr_q          <= '0;
            data_q          <= '0;
            req0_ready      <= 1'b0;
            req0_err        <= 1'b0;
            req1_ready      <= 1'b0;
            req1_err        <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
`ifdef CFG_ERR_COUNT_EN
            err_count       <= '0;
`endif
        end else begin
            req0_ready <= 1'b0;
            req0_err   <= 1'b0;
            req1_ready <= 1'b0;
            req1_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        gid_q  <= grant;
                        addr_q <= grant ? req1_addr : req0_addr;
                        data_q <= grant ? req1_data : req0_data;
                        busy   <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (addr_ok) begin
                        case (addr_q)
                            ADDR_EN_REG_OUT_7_0:  en_reg_out_7_0  <= data_q;
                            ADDR_EN_REG_OUT_15_8: en_reg_out_15_8 <= data_q;
                            ADDR_EN_REG_PWM_7_0:  en_reg_pwm_7_0  <= data_q;
                            ADDR_EN_REG_PWM_15_8: en_reg_pwm_15_8 <= data_q;
                            ADDR_PWM_DUTY_CYCLE:  pwm_duty_cycle  <= data_q;
                            default: ;
                        endcase
                    end
`ifdef CFG_ERR_COUNT_EN
                    else if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
`endif
                    // Response flags are registered here so they appear in the RESP cycle.
                    if (gid_q) begin
                        req1_ready <= 1'b1;
                        req1_err   <= ~addr_ok;
                    end else begin
                        req0_ready <= 1'b1;
                        req0_err   <= ~addr_ok;
                    end
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
